// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin pick among finished functional units,
// registered one-cycle broadcast of the winner's result and ROB destination.
module cdb_arbiter #(
    parameter int FU_NUM    = 4,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 3,
    parameter int RB_SIZE   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FU_NUM-1:0]             valid_bus,
    input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
    input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
    input  logic                          flush,
    output logic [FU_NUM-1:0]             grant,
    output logic                          cdb_valid,
    output logic [WORD_SIZE-1:0]          cdb_data,
    output logic [RB_INDEX-1:0]           cdb_rb_index,
    output logic [RB_SIZE-1:0]            CDB_data_valid,
    output logic [15:0]                   conflict_count
);

    localparam int PTR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W:0]       scan_sum;
    logic [FU_NUM-1:0]    eligible;
    logic                 win_found;
    logic                 contended;
    logic [WORD_SIZE-1:0] data_arr  [FU_NUM];
    logic [RB_INDEX-1:0]  index_arr [FU_NUM];

    for (genvar i = 0; i < FU_NUM; i++) begin : g_unpack
        assign data_arr[i]  = data_bus[i*WORD_SIZE +: WORD_SIZE];
        assign index_arr[i] = RB_index_bus[i*RB_INDEX +: RB_INDEX];
    end

    // A unit that holds the grant this cycle sits out one edge, which keeps
    // a never-dropped request from winning twice in a row.
    always_comb begin
        eligible  = valid_bus & ~grant;
        contended = |(eligible & (eligible - FU_NUM'(1)));
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        cand      = '0;
        // Scan backwards so the last hit is the first unit at or after ptr.
        for (int k = FU_NUM - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(FU_NUM)) begin
                scan_sum = scan_sum - (PTR_W+1)'(FU_NUM);
            end
            cand = scan_sum[PTR_W-1:0];
            if (eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        next_ptr = (win_idx == PTR_W'(FU_NUM - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant          <= '0;
            cdb_valid      <= 1'b0;
            cdb_data       <= '0;
            cdb_rb_index   <= '0;
            ptr            <= '0;
            conflict_count <= '0;
        end else if (flush) begin
            grant     <= '0;
            cdb_valid <= 1'b0;
        end else begin
            if (contended && conflict_count != 16'hFFFF) begin
                conflict_count <= conflict_count + 16'd1;
            end
            if (win_found) begin
                grant        <= FU_NUM'(1) << win_idx;
                cdb_valid    <= 1'b1;
                cdb_data     <= data_arr[win_idx];
                cdb_rb_index <= index_arr[win_idx];
                ptr          <= next_ptr;
            end else begin
                grant     <= '0;
                cdb_valid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < RB_SIZE; k++) begin : g_decode
        assign CDB_data_valid[k] = cdb_valid && (cdb_rb_index == RB_INDEX'(k));
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a
// transaction-level round-robin model with FU handshake emulation.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   valid_bus;
    logic [127:0] data_bus;
    logic [11:0]  RB_index_bus;
    logic         flush;
    logic [3:0]   grant;
    logic         cdb_valid;
    logic [31:0]  cdb_data;
    logic [2:0]   cdb_rb_index;
    logic [7:0]   CDB_data_valid;
    logic [15:0]  conflict_count;

    cdb_arbiter #(.FU_NUM(4), .WORD_SIZE(32), .RB_INDEX(3), .RB_SIZE(8)) dut (
        .clk(clk), .reset(reset), .valid_bus(valid_bus), .data_bus(data_bus),
        .RB_index_bus(RB_index_bus), .flush(flush), .grant(grant),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rb_index(cdb_rb_index),
        .CDB_data_valid(CDB_data_valid), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // FU-side request state
    logic [3:0]  v = '0;
    logic [31:0] d  [4];
    logic [2:0]  ix [4];
    bit          fl = 0;
    bit          rst = 0;
    bit          auto_drop = 1;

    // reference model state: granted FU (-1 none), pointer, counter, broadcast
    int          mg = -1;
    int          mp = 0;
    int          mc = 0;
    int          mi = 0;
    logic [31:0] md = '0;
    bit          mv = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input bit chk);
        int old_g, ne, w, fu;
        old_g = mg;
        valid_bus = v;
        flush     = fl;
        reset     = rst;
        for (int i = 0; i < 4; i++) begin
            data_bus[i*32 +: 32]    = d[i];
            RB_index_bus[i*3 +: 3]  = ix[i];
        end
        if (rst) begin
            mg = -1; mv = 0; md = '0; mi = 0; mp = 0; mc = 0;
        end else if (fl) begin
            mg = -1; mv = 0;
        end else begin
            ne = 0;
            w  = -1;
            for (int i = 0; i < 4; i++) if (v[i] && i != old_g) ne++;
            if (ne >= 2 && mc < 65535) mc++;
            for (int k = 0; k < 4; k++) begin
                fu = (mp + k) % 4;
                if (w < 0 && v[fu] && fu != old_g) w = fu;
            end
            if (w >= 0) begin
                mg = w; mv = 1; md = d[w]; mi = int'(ix[w]); mp = (w + 1) % 4;
            end else begin
                mg = -1; mv = 0;
            end
        end
        @(negedge clk);
        if (chk) begin
            check_eq("grant", 64'(grant), (mg >= 0) ? (64'd1 << mg) : 64'd0);
            check_eq("cdb_valid", 64'(cdb_valid), 64'(mv));
            check_eq("cdb_data", 64'(cdb_data), 64'(md));
            check_eq("cdb_rb_index", 64'(cdb_rb_index), 64'(mi));
            check_eq("CDB_data_valid", 64'(CDB_data_valid), mv ? (64'd1 << mi) : 64'd0);
            check_eq("conflict_count", 64'(conflict_count), 64'(mc));
        end
        // the granted FU sees grant at the following edge and drops valid there
        if (auto_drop && old_g >= 0) v[old_g] = 1'b0;
    endtask

    task automatic drain();
        auto_drop = 1;
        v = '0;
        step(1);
        step(1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            d[i]  = '0;
            ix[i] = '0;
        end

        // reset state
        rst = 1;
        step(1);
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_valid", 64'(cdb_valid), 64'd0);
        check_eq("rst_count", 64'(conflict_count), 64'd0);
        rst = 0;

        // single request
        v = 4'b0100; d[2] = 32'hDEADBEEF; ix[2] = 3'd5;
        step(1);
        check_eq("single_grant", 64'(grant), 64'h4);
        check_eq("single_data", 64'(cdb_data), 64'hDEADBEEF);
        check_eq("single_dv", 64'(CDB_data_valid), 64'h20);
        v[0] = 1; d[0] = 32'h11110000; ix[0] = 3'd1;
        v[3] = 1; d[3] = 32'h33330000; ix[3] = 3'd3;
        step(1);
        check_eq("ptr3_grant", 64'(grant), 64'h8);
        step(1);
        drain();

        // round robin with all four requesting
        rst = 1; step(1); rst = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = 32'hA0 + i; ix[i] = 3'(i + 4);
        end
        v = 4'b1111;
        step(1); check_eq("rr_g0", 64'(grant), 64'h1);
        step(1); check_eq("rr_g1", 64'(grant), 64'h2);
        step(1); check_eq("rr_g2", 64'(grant), 64'h4);
        step(1); check_eq("rr_g3", 64'(grant), 64'h8);
        check_eq("rr_count", 64'(conflict_count), 64'd3);
        drain();

        // wrap-around from ptr=3
        v = 4'b0100; step(1); step(1);
        v = 4'b0011; d[0] = 32'h0BAD0000; d[1] = 32'h0BAD0001;
        step(1); check_eq("wrap_g0", 64'(grant), 64'h1);
        step(1); check_eq("wrap_g1", 64'(grant), 64'h2);
        step(1);
        v = 4'b1011;
        step(1); check_eq("wrap_ptr2", 64'(grant), 64'h8);
        drain();

        // FU 1 never drops its request
        auto_drop = 0;
        v = 4'b0010;
        step(1); check_eq("guard_e1", 64'(grant[1]), 64'd1);
        step(1); check_eq("guard_e2", 64'(grant[1]), 64'd0);
        step(1); check_eq("guard_e3", 64'(grant[1]), 64'd1);
        drain();

        // flush on the same edge as a request
        v = 4'b0010; fl = 1;
        step(1);
        check_eq("flush_grant", 64'(grant), 64'd0);
        check_eq("flush_valid", 64'(cdb_valid), 64'd0);
        fl = 0;
        step(1); check_eq("after_flush", 64'(grant), 64'h2);
        drain();

        // random traffic with occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!v[i] && $urandom_range(2) == 0) begin
                    v[i]  = 1'b1;
                    d[i]  = $urandom;
                    ix[i] = 3'($urandom_range(7));
                end
            end
            fl  = ($urandom_range(15) == 0);
            rst = ($urandom_range(127) == 0);
            step(1);
        end
        fl = 0; rst = 0;
        drain();

        // counter saturation under permanent contention
        rst = 1; step(1); rst = 0;
        auto_drop = 0;
        v = 4'b1111;
        for (int n = 0; n < 65540; n++) step(0);
        step(1);
        check_eq("sat_count", 64'(conflict_count), 64'hFFFF);
        rst = 1; fl = 1;
        step(1);
        check_eq("rf_grant", 64'(grant), 64'd0);
        check_eq("rf_valid", 64'(cdb_valid), 64'd0);
        check_eq("rf_data", 64'(cdb_data), 64'd0);
        check_eq("rf_index", 64'(cdb_rb_index), 64'd0);
        check_eq("rf_dv", 64'(CDB_data_valid), 64'd0);
        check_eq("rf_count", 64'(conflict_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
